// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory arbiter slice.
//   req_id_t : requester identity; its value is also the bit index into req vectors
//   state_t  : arbiter FSM state
//   next_req : cyclic successor CPU -> ACL -> DMA -> CPU
package mem_arb_pkg;

   localparam int NUM_REQ = 3;

   typedef enum logic [1:0] {
      REQ_CPU = 2'd0,
      REQ_ACL = 2'd1,
      REQ_DMA = 2'd2
   } req_id_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   function automatic req_id_t next_req(input req_id_t id);
      req_id_t nxt;
      case (id)
         REQ_CPU: nxt = REQ_ACL;
         REQ_ACL: nxt = REQ_DMA;
         default: nxt = REQ_CPU;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection among the three requesters.
//   Build option MEM_ARB_RR_EN:
//     defined   : round-robin, search starts at the requester after `last`
//     undefined : fixed priority DMA > ACL > CPU, `last` ignored
// Ports
//   req    in   NUM_REQ  request vector, indexed by req_id_t
//   last   in   req_id_t most recently granted requester
//   winner out  req_id_t selected requester (meaningful only when any=1)
//   any    out  1        at least one request present
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            last,
   output req_id_t            winner,
   output logic               any
);

   assign any = |req;

`ifdef MEM_ARB_RR_EN
   req_id_t cand;
   logic    found;

   always_comb begin
      winner = REQ_CPU;
      found  = 1'b0;
      cand   = last;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = next_req(cand);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end
`else
   logic unused_last;
   assign unused_last = ^last;

   always_comb begin
      if (req[REQ_DMA]) begin
         winner = REQ_DMA;
      end else if (req[REQ_ACL]) begin
         winner = REQ_ACL;
      end else begin
         winner = REQ_CPU;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port memory_controller between CPU, accelerator (ACL) and
//   DMA. One access outstanding at a time; the completion is routed back to the
//   requester that owns the access. Arbitration policy is selected by the
//   MEM_ARB_RR_EN build macro (round-robin when defined, fixed DMA>ACL>CPU otherwise).
// Ports (x in cpu/acl/dma)
//   clk, rst            clock; asynchronous active-high reset
//   x_req/we/addr/wdata request, held stable until x_gnt
//   x_gnt               1-cycle pulse, request accepted
//   x_done / x_err      1-cycle completion pulse / timeout flag with done
//   x_rdata             last read data for that requester
//   mem_en/we/addr/wdata registered access strobe and payload to the controller
//   mem_rdata/mem_valid completion from the controller (reads and writes)
//
// state | meaning
// IDLE  | no access in flight; arbitrate among requests each cycle
// ISSUE | mem_en and owner gnt high this cycle; timer cleared
// WAIT  | waiting for mem_valid or timer terminal count
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 28,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_done,
   output logic                  cpu_err,
   output logic [DATA_WIDTH-1:0] cpu_rdata,

   input  logic                  acl_req,
   input  logic                  acl_we,
   input  logic [ADDR_WIDTH-1:0] acl_addr,
   input  logic [DATA_WIDTH-1:0] acl_wdata,
   output logic                  acl_gnt,
   output logic                  acl_done,
   output logic                  acl_err,
   output logic [DATA_WIDTH-1:0] acl_rdata,

   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_gnt,
   output logic                  dma_done,
   output logic                  dma_err,
   output logic [DATA_WIDTH-1:0] dma_rdata,

   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_valid
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   state_t                  state;
   req_id_t                 owner;
   req_id_t                 winner;
   req_id_t                 last_gnt;
   logic                    any_req;
   logic [TIMER_W-1:0]      timer;
   logic [NUM_REQ-1:0]      req_vec;
   logic [NUM_REQ-1:0]      gnt_q;
   logic [NUM_REQ-1:0]      done_q;
   logic [NUM_REQ-1:0]      err_q;
   logic [DATA_WIDTH-1:0]   rdata_q [NUM_REQ];

   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   assign req_vec = {dma_req, acl_req, cpu_req};

`ifndef MEM_ARB_RR_EN
   assign last_gnt = REQ_CPU;
`endif

   mem_arb_pick u_pick (
      .req    (req_vec),
      .last   (last_gnt),
      .winner (winner),
      .any    (any_req)
   );

   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      case (winner)
         REQ_ACL: begin
            sel_we    = acl_we;
            sel_addr  = acl_addr;
            sel_wdata = acl_wdata;
         end
         REQ_DMA: begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= REQ_CPU;
         timer     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            rdata_q[i] <= '0;
         end
`ifdef MEM_ARB_RR_EN
         // Treat DMA as last granted so the first search starts at CPU.
         last_gnt  <= REQ_DMA;
`endif
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         err_q  <= '0;
         mem_en <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner         <= winner;
                  mem_we        <= sel_we;
                  mem_addr      <= sel_addr;
                  mem_wdata     <= sel_wdata;
                  mem_en        <= 1'b1;
                  gnt_q[winner] <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT;
`ifdef MEM_ARB_RR_EN
               last_gnt <= owner;
`endif
            end
            WAIT: begin
               // A completion arriving on the terminal-count cycle still counts as success.
               if (mem_valid) begin
                  done_q[owner] <= 1'b1;
                  if (!mem_we) begin
                     rdata_q[owner] <= mem_rdata;
                  end
                  state <= IDLE;
               end else if (timer == TIMER_LAST) begin
                  done_q[owner] <= 1'b1;
                  err_q[owner]  <= 1'b1;
                  state         <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cpu_gnt   = gnt_q[REQ_CPU];
   assign acl_gnt   = gnt_q[REQ_ACL];
   assign dma_gnt   = gnt_q[REQ_DMA];
   assign cpu_done  = done_q[REQ_CPU];
   assign acl_done  = done_q[REQ_ACL];
   assign dma_done  = done_q[REQ_DMA];
   assign cpu_err   = err_q[REQ_CPU];
   assign acl_err   = err_q[REQ_ACL];
   assign dma_err   = err_q[REQ_DMA];
   assign cpu_rdata = rdata_q[REQ_CPU];
   assign acl_rdata = rdata_q[REQ_ACL];
   assign dma_rdata = rdata_q[REQ_DMA];

endmodule
